rotate_cmd_sequencer: RTL and testbench

Upstream command stage for the 16-bit right-rotate datapath. It accepts rotate commands (data, amount) over a valid/ready handshake and buffers them in a small FIFO. A serial engine rotates one bit position per cycle and presents each result on a valid/ready output. It serves as the low-area, multi-cycle companion to the combinational barrel rotator, and its results are bit-exact against that rotator's intended function.

---
 rtl/rotate_cmd_sequencer.sv | 125 ++++++++++++
 tb/tb_rotate_cmd_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rotate_cmd_sequencer.sv
// Command FIFO feeding a serial rotate engine that moves one bit per cycle.
// Optional macro ROT_LEFT_EN adds a per-command rotate direction (in_dir).
module rotate_cmd_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [AMT_W-1:0]           in_amt,
`ifdef ROT_LEFT_EN
  input  logic                       in_dir,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       busy
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [AMT_W-1:0] amt_mem  [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             push, pop, rot_left;

  assign in_ready   = (count_q < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == IDLE) && (count_q != '0);
  assign fifo_count = count_q;
  assign out_data   = work_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

`ifdef ROT_LEFT_EN
  logic dir_mem [DEPTH];
  logic dir_q, dir_d;
  assign rot_left = dir_q;
  always_ff @(posedge clk) if (push) dir_mem[wr_ptr_q] <= in_dir;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dir_q <= 1'b0;
    else        dir_q <= dir_d;
  assign dir_d = pop ? dir_mem[rd_ptr_q] : dir_q;
`else
  assign rot_left = 1'b0;
`endif

  // Storage has no reset; only pointers/count define what is valid.
  always_ff @(posedge clk)
    if (push) begin
      data_mem[wr_ptr_q] <= in_data;
      amt_mem[wr_ptr_q]  <= in_amt;
    end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end

  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    case (state_q)
      IDLE: if (pop) begin
        work_d = data_mem[rd_ptr_q];
        cnt_d  = amt_mem[rd_ptr_q];
      end
      SHIFT: begin
        work_d = rot_left ? {work_q[WIDTH-2:0], work_q[WIDTH-1]}
                          : {work_q[0], work_q[WIDTH-1:1]};
        cnt_d  = cnt_q - AMT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pop) state_d = (amt_mem[rd_ptr_q] == '0) ? DONE : SHIFT;
      SHIFT: if (cnt_q == AMT_W'(1)) state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    if (state_q == DONE) out_valid = 1'b1;
  end
endmodule

// File: tb/tb_rotate_cmd_sequencer.sv
// Randomized bench for rotate_cmd_sequencer with a transaction-level rotate model.
module tb_rotate_cmd_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [15:0] in_data = '0, out_data;
  logic [3:0]  in_amt = '0;
  logic [2:0]  fifo_count;
`ifdef ROT_LEFT_EN
  logic        in_dir = 1'b0;
`endif
  int          total = 0, bad = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  rotate_cmd_sequencer #(.WIDTH(16), .AMT_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
`ifdef ROT_LEFT_EN
    .in_dir(in_dir),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_count(fifo_count), .busy(busy)
  );

  function automatic logic [15:0] rot_ref(input logic [15:0] d, input int a, input bit left);
    logic [31:0] dd;
    int sh;
    dd = {d, d};
    sh = left ? (16 - a) % 16 : a;
    return 16'(dd >> sh);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [15:0] d, input logic [3:0] a, input bit left);
    in_data = d;
    in_amt  = a;
`ifdef ROT_LEFT_EN
    in_dir  = left;
`endif
  endtask

  task automatic run_one(input logic [15:0] d, input logic [3:0] a, input bit left);
    int n;
    drive_cmd(d, a, left);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk("one_rdy", in_ready, 1);
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin tick; n++; end
    chk("one_lat", n, a + 1);
    chk("one_data", out_data, rot_ref(d, a, left));
    tick;
    chk("one_vld_drop", out_valid, 0);
  endtask

  task automatic drain(input string tag);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      if (out_valid) begin
        chk(tag, out_data, q[0]);
        void'(q.pop_front());
      end
      tick;
      n++;
    end
    chk({tag, "_empty"}, q.size(), 0);
  endtask

  initial begin
    int acc, seen;
    bit hold, dr;
    logic [15:0] d;
    logic [3:0]  a;

    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    chk("rst_vld", out_valid, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_data", out_data, 16'h0000);

    run_one(16'h8001, 4'd1, 1'b0);
    run_one(16'h1234, 4'd0, 1'b0);
    run_one(16'h1234, 4'd4, 1'b0);
    run_one(16'h0001, 4'd15, 1'b0);
    chk("const_c000", rot_ref(16'h8001, 1, 0), 16'hC000);

    // Backpressure: engine holds one result, FIFO fills to DEPTH.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      dr = 1'b0;
`ifdef ROT_LEFT_EN
      dr = 1'($urandom_range(0, 1));
`endif
      drive_cmd(16'($urandom), 4'($urandom), dr);
      in_valid = 1'b1;
      if (in_ready) begin
        acc++;
        q.push_back(rot_ref(in_data, in_amt, dr));
      end
      tick;
    end
    in_valid = 1'b0;
    chk("bp_acc", acc, 5);
    chk("bp_cnt", fifo_count, 4);
    chk("bp_rdy", in_ready, 0);
    chk("bp_vld", out_valid, 1);
    chk("bp_data0", out_data, q[0]);
    void'(q.pop_front());
    out_ready = 1'b1;
    tick;
    chk("bp_cnt_after_hs", fifo_count, 4);
    chk("bp_rdy_after_hs", in_ready, 0);
    tick;
    chk("bp_cnt_after_pop", fifo_count, 3);
    chk("bp_rdy_after_pop", in_ready, 1);
    drain("bp_order");

    // Random traffic against the scoreboard.
    hold = 1'b0;
    for (int i = 0; i < 600; i++) begin
      dr = 1'b0;
`ifdef ROT_LEFT_EN
      dr = 1'($urandom_range(0, 1));
`endif
      d = 16'($urandom);
      a = 4'($urandom_range(0, 15));
      drive_cmd(d, a, dr);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      if (hold) chk("rnd_vld_hold", out_valid, 1);
      chk("rnd_busy", busy, q.size() != 0);
      if (out_valid) begin
        if (q.size() == 0) chk("rnd_spurious", out_valid, 0);
        else               chk("rnd_data", out_data, q[0]);
      end
      hold = out_valid && !out_ready;
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(rot_ref(d, a, dr));
      tick;
    end
    drain("rnd_drain");

    // Reset during SHIFT with commands queued behind it.
    out_ready = 1'b1;
    drive_cmd(16'hFFFF, 4'd7, 1'b0);
    in_valid = 1'b1;
    tick;
    drive_cmd(16'hA5A5, 4'd3, 1'b0);
    repeat (3) tick;
    in_valid = 1'b0;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", fifo_count, 0);
    chk("mid_rst_data", out_data, 16'h0000);
    tick;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen++;
      tick;
    end
    chk("mid_no_result", seen, 0);
    chk("mid_cnt_after", fifo_count, 0);
    q.delete();

`ifdef ROT_LEFT_EN
    run_one(16'h8001, 4'd1, 1'b1);
    chk("left_const", rot_ref(16'h8001, 1, 1), 16'h0003);
    run_one(16'h8001, 4'd1, 1'b0);
    run_one(16'h0001, 4'd15, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
